// File: rtl/fp16_to_fixed.sv
// FP16 to signed fixed-point Q(OUT_W-FRAC_BITS).FRAC_BITS converter.
// Two-stage valid/ready pipeline: decode, then align/sign/saturate with status flags.
module fp16_to_fixed #(
    parameter int OUT_W     = 24,
    parameter int FRAC_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_overflow,
    output logic                    out_zero,
    output logic                    out_nan,
    output logic                    out_inexact
);
    // Wide enough for an 11-bit mantissa shifted by the largest left shift
    // (FRAC_BITS + 6 <= OUT_W + 4) before the range check.
    localparam int MAG_W = OUT_W + 16;
    localparam int SH_W  = 8;

    localparam logic signed [SH_W-1:0] SH_BIAS = SH_W'(25 - FRAC_BITS);
    localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(1) << (OUT_W - 1);
    localparam logic [MAG_W-1:0] POS_LIM = NEG_LIM - MAG_W'(1);
    localparam logic signed [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] NEG_MAX = {1'b1, {(OUT_W-1){1'b0}}};

    // Returns {inexact, magnitude}; right shifts truncate toward zero.
    function automatic logic [MAG_W:0] align_mag(input logic [10:0] mant,
                                                 input logic signed [SH_W-1:0] sh);
        logic [MAG_W-1:0] wide;
        logic [SH_W-1:0]  rsh;
        logic [10:0]      mask;
        logic             inx;
        wide = '0;
        rsh  = '0;
        mask = '0;
        inx  = 1'b0;
        if (!sh[SH_W-1]) begin
            wide = {{(MAG_W-11){1'b0}}, mant} << sh;
        end else begin
            rsh = -sh;
            if (rsh >= SH_W'(11)) begin
                inx = |mant;
            end else begin
                wide = {{(MAG_W-11){1'b0}}, (mant >> rsh)};
                mask = ~(11'h7ff << rsh);
                inx  = |(mant & mask);
            end
        end
        return {inx, wide};
    endfunction

    // Returns {overflow, value}; -2^(OUT_W-1) is representable exactly.
    function automatic logic [OUT_W:0] saturate(input logic sign,
                                                input logic [MAG_W-1:0] mag);
        logic [OUT_W-1:0] val;
        val = mag[OUT_W-1:0];
        if (!sign && (mag > POS_LIM)) return {1'b1, POS_MAX};
        if (sign && (mag > NEG_LIM))  return {1'b1, NEG_MAX};
        return {1'b0, (sign ? -val : val)};
    endfunction

    logic                   s1_adv, s2_adv;
    logic                   vld_p1, vld_p2;
    logic                   sign_p1, nan_p1, inf_p1;
    logic [10:0]            mant_p1;
    logic signed [SH_W-1:0] shift_p1;

    assign s2_adv    = !vld_p2 || out_ready;
    assign s1_adv    = !vld_p1 || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = vld_p2;

    // ---- stage 1: decode ----
    logic [4:0]             exp_in;
    logic [9:0]             frac_in;
    logic [4:0]             e_eff;
    logic signed [SH_W-1:0] shift_in;

    assign exp_in   = in_data[14:10];
    assign frac_in  = in_data[9:0];
    assign e_eff    = (exp_in == 5'd0) ? 5'd1 : exp_in;
    assign shift_in = $signed({3'b000, e_eff}) - SH_BIAS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (s1_adv) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            sign_p1  <= in_data[15];
            mant_p1  <= {(exp_in != 5'd0), frac_in};
            shift_p1 <= shift_in;
            nan_p1   <= (exp_in == 5'd31) && (frac_in != 10'd0);
            inf_p1   <= (exp_in == 5'd31) && (frac_in == 10'd0);
        end
    end

    // ---- stage 2: shift, sign, saturate ----
    logic [MAG_W:0]          al_p1;
    logic [OUT_W:0]          sat_p1;
    logic signed [OUT_W-1:0] data_p1;
    logic                    ovf_p1, inx_p1;

    always_comb begin
        al_p1   = align_mag(mant_p1, shift_p1);
        sat_p1  = saturate(sign_p1, al_p1[MAG_W-1:0]);
        data_p1 = sat_p1[OUT_W-1:0];
        ovf_p1  = sat_p1[OUT_W];
        inx_p1  = al_p1[MAG_W] && !sat_p1[OUT_W];
        if (nan_p1) begin
            data_p1 = '0;
            ovf_p1  = 1'b0;
            inx_p1  = 1'b0;
        end else if (inf_p1) begin
            data_p1 = sign_p1 ? NEG_MAX : POS_MAX;
            ovf_p1  = 1'b1;
            inx_p1  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2       <= 1'b0;
            out_data     <= '0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            out_nan      <= 1'b0;
            out_inexact  <= 1'b0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_data     <= data_p1;
                out_overflow <= ovf_p1;
                out_zero     <= (data_p1 == '0);
                out_nan      <= nan_p1;
                out_inexact  <= inx_p1;
            end
        end
    end

endmodule

// File: tb/tb_fp16_to_fixed.sv
// Bench for fp16_to_fixed: real-arithmetic reference model with a scoreboard,
// directed vectors carrying hand-computed results, backpressure, reset and random traffic.
module tb_fp16_to_fixed;
    localparam int OUT_W     = 24;
    localparam int FRAC_BITS = 8;
    localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_MAX = {1'b1, {(OUT_W-1){1'b0}}};

    typedef logic [OUT_W+3:0] res_t;  // {data, overflow, zero, nan, inexact}
    typedef struct packed {
        res_t m;
        logic has_lit;
        res_t lit;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [15:0]             in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_overflow, out_zero, out_nan, out_inexact;

    always #5 clk = ~clk;

    fp16_to_fixed #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_overflow(out_overflow), .out_zero(out_zero),
        .out_nan(out_nan), .out_inexact(out_inexact)
    );

    res_t dut_res;
    assign dut_res = {out_data, out_overflow, out_zero, out_nan, out_inexact};

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    logic lit_en;
    res_t lit_val;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Value = mant * 2^(e_eff-25) scaled by 2^FRAC_BITS, truncated toward zero.
    function automatic res_t model(input logic [15:0] x);
        logic             s, ovf, nan, inx;
        logic [OUT_W-1:0] d;
        int               e, f, mnt, ee;
        real              mag, fl, lim;
        s = x[15];
        e = int'(x[14:10]);
        f = int'(x[9:0]);
        ovf = 1'b0; nan = 1'b0; inx = 1'b0; d = '0;
        lim = $pow(2.0, real'(OUT_W - 1));
        if (e == 31 && f != 0) begin
            nan = 1'b1;
        end else if (e == 31) begin
            ovf = 1'b1;
            d = s ? NEG_MAX : POS_MAX;
        end else begin
            mnt = (e == 0) ? f : f + 1024;
            ee  = (e == 0) ? 1 : e;
            mag = real'(mnt) * $pow(2.0, real'(ee - 25 + FRAC_BITS));
            fl  = $floor(mag);
            if (!s && fl > lim - 1.0) begin
                ovf = 1'b1; d = POS_MAX;
            end else if (s && fl > lim) begin
                ovf = 1'b1; d = NEG_MAX;
            end else begin
                inx = (mag != fl);
                d = OUT_W'(s ? -longint'(fl) : longint'(fl));
            end
        end
        return {d, ovf, (d == '0), nan, inx};
    endfunction

    exp_t e_pop;
    logic stall_prev = 1'b0;
    res_t held;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) check("hold_stable", dut_res, held);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e_pop = sb.pop_front();
                    check("model", dut_res, e_pop.m);
                    if (e_pop.has_lit) check("literal", dut_res, e_pop.lit);
                end
            end
            if (in_valid && in_ready) sb.push_back({model(in_data), lit_en, lit_val});
            stall_prev = out_valid && !out_ready;
            held = dut_res;
        end
    end

    task automatic send(input logic [15:0] x, input logic has, input res_t lit);
        logic take;
        int   guard;
        in_valid = 1'b1; in_data = x; lit_en = has; lit_val = lit;
        guard = 0;
        take = 1'b0;
        do begin
            @(negedge clk); take = in_ready;
            @(posedge clk); #1;
            guard++;
        end while (!take && guard < 200);
        if (!take) check("accept_timeout", 0, 1);
        in_valid = 1'b0; lit_en = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [15:0] DV [10] = '{16'h7BFF, 16'hF800, 16'h7C00, 16'hFC00, 16'h7E00,
                                        16'h8000, 16'h0001, 16'h0000, 16'hFBFF, 16'h3A00};
    localparam res_t DR [10] = '{{24'h7FFFFF, 4'b1000}, {24'h800000, 4'b0000},
                                 {24'h7FFFFF, 4'b1000}, {24'h800000, 4'b1000},
                                 {24'h000000, 4'b0110}, {24'h000000, 4'b0100},
                                 {24'h000000, 4'b0101}, {24'h000000, 4'b0100},
                                 {24'h800000, 4'b1000}, {24'h0000C0, 4'b0000}};
    localparam logic [15:0] BV [3] = '{16'h4000, 16'hBC00, 16'h3800};
    localparam res_t BR [3] = '{{24'h000200, 4'b0000}, {24'hFFFF00, 4'b0000},
                                {24'h000080, 4'b0000}};

    initial begin
        int   acc_cnt, sent, cyc;
        logic take;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        lit_en = 1'b0; lit_val = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_outputs", dut_res, 0);
        @(posedge clk); #1;

        // Latency: accepted on one edge, valid after the next.
        send(16'h3C00, 1'b1, {24'h000100, 4'b0000});
        @(negedge clk); check("latency_c1", out_valid, 0);
        @(negedge clk); check("latency_c2", out_valid, 1);
        drain(3);

        // Back-to-back results on consecutive cycles.
        send(16'hC100, 1'b1, {24'hFFFD80, 4'b0000});
        send(16'h3555, 1'b1, {24'h000055, 4'b0001});
        @(negedge clk); check("b2b_first", out_valid, 1);
        @(negedge clk); check("b2b_second", out_valid, 1);
        drain(3);

        for (int i = 0; i < 10; i++) begin
            send(DV[i], 1'b1, DR[i]);
            drain(3);
        end

        // Backpressure: only two items fit while the output is stalled.
        out_ready = 1'b0;
        acc_cnt = 0;
        in_valid = 1'b1; in_data = BV[0]; lit_en = 1'b1; lit_val = BR[0];
        repeat (6) begin
            @(negedge clk); take = in_ready;
            @(posedge clk); #1;
            if (take) begin
                acc_cnt++;
                in_data = BV[acc_cnt]; lit_val = BR[acc_cnt];
            end
        end
        check("bp_accepted", acc_cnt, 2);
        check("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk); check("bp_rel_v0", out_valid, 1); check("bp_rel_ready", in_ready, 1);
        @(posedge clk); #1; in_valid = 1'b0; lit_en = 1'b0;
        @(negedge clk); check("bp_rel_v1", out_valid, 1);
        @(negedge clk); check("bp_rel_v2", out_valid, 1);
        @(negedge clk); check("bp_drained", out_valid, 0);
        @(posedge clk); #1;

        // Reset with both stages full.
        out_ready = 1'b0;
        send(16'h3C00, 1'b0, '0);
        send(16'h4000, 1'b0, '0);
        check("rst_pre_full", out_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_data", dut_res, 0);
        drain(2);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);
        @(posedge clk); #1;
        send(16'h3C00, 1'b1, {24'h000100, 4'b0000});
        drain(4);
        check("post_rst_sb_empty", sb.size(), 0);

        // Random valid/ready traffic against the model.
        sent = 0; cyc = 0;
        while (sent < 10000 && cyc < 60000) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = 16'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk); take = in_valid && in_ready;
            @(posedge clk); #1;
            if (take) begin
                sent++;
                in_valid = 1'b0;
            end
            cyc++;
        end
        check("random_sent", sent, 10000);
        in_valid = 1'b0; out_ready = 1'b1;
        drain(5);
        check("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
